// File: rtl/axi_timer_irq_if.sv
// AXI4 bus bundle shared by the xbar and the timer slave.
// Master/Slave modports carry the five valid/ready channels.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_lock, aw_cache, aw_prot, aw_qos, aw_region,
    output aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_lock, ar_cache, ar_prot, ar_qos, ar_region,
    output ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_lock, aw_cache, aw_prot, aw_qos, aw_region,
    input  aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_lock, ar_cache, ar_prot, ar_qos, ar_region,
    input  ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_timer_irq.sv
// AXI4 machine timer (mtime/mtimecmp, prescaler, ack counter).
// Define AXI_TIMER_SWI_EN to map MSIP at 0x1C onto irq_o[3].
module axi_timer_irq #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned PRESCALE_RESET = 0,
  parameter int unsigned TIMER_IRQ_ID   = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  AXI_BUS.Slave       AXI_Slave,
  output logic [31:0] irq_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i
);

  if (AXI_DATA_WIDTH != 32) begin : g_bad_dw
    $fatal(1, "axi_timer_irq: AXI_DATA_WIDTH must be 32");
  end

`ifdef AXI_TIMER_SWI_EN
  localparam logic SWI = 1'b1;
`else
  localparam logic SWI = 1'b0;
`endif

  localparam logic [2:0] A_MTL = 3'd0;
  localparam logic [2:0] A_MTH = 3'd1;
  localparam logic [2:0] A_CML = 3'd2;
  localparam logic [2:0] A_CMH = 3'd3;
  localparam logic [2:0] A_PRE = 3'd4;
  localparam logic [2:0] A_CTL = 3'd5;
  localparam logic [2:0] A_ACK = 3'd6;
  localparam logic [2:0] A_SWI = 3'd7;

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE, R_DATA
  } rstate_e;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = s[i] ? d[i*8 +: 8] : old[i*8 +: 8];
    end
    return m;
  endfunction

  wstate_e r_wstate, w_wnext;
  rstate_e r_rstate, w_rnext;

  logic                      r_live;
  logic [AXI_ID_WIDTH-1:0]   r_awid;
  logic [AXI_ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]                r_awlen;
  logic                      r_werr;
  logic [AXI_ID_WIDTH-1:0]   r_arid;
  logic [AXI_ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]                r_arlen;
  logic [7:0]                r_rcnt;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic        r_en;
  logic [31:0] r_ackcnt;
  logic        r_tirq;
  logic        w_msip;

  logic w_awready, w_wready, w_bvalid;
  logic w_arready, w_rvalid, w_rlast;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic w_tick, w_ack_t;

  logic [7:0][31:0] w_regs;
  logic [2:0]       w_wsel, w_rsel;
  logic [31:0]      w_wval;
  logic             w_wbad, w_rbad;
  logic w_we_mtl, w_we_mth, w_we_cml, w_we_cmh;
  logic w_we_pre, w_we_ctl;

  always_comb begin
    w_wnext   = r_wstate;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_awready = r_live;
        if (r_live && AXI_Slave.aw_valid) w_wnext = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (AXI_Slave.w_valid && AXI_Slave.w_last)
          w_wnext = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (AXI_Slave.b_ready) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rnext   = r_rstate;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    w_rlast   = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        w_arready = r_live;
        if (r_live && AXI_Slave.ar_valid) w_rnext = R_DATA;
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        w_rlast  = (r_rcnt == r_arlen);
        if (AXI_Slave.r_ready && w_rlast) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  assign w_aw_hs = w_awready && AXI_Slave.aw_valid;
  assign w_w_hs  = w_wready  && AXI_Slave.w_valid;
  assign w_ar_hs = w_arready && AXI_Slave.ar_valid;
  assign w_r_hs  = w_rvalid  && AXI_Slave.r_ready;

  always_comb begin
    w_regs    = '0;
    w_regs[0] = r_mtime[31:0];
    w_regs[1] = r_mtime[63:32];
    w_regs[2] = r_mtimecmp[31:0];
    w_regs[3] = r_mtimecmp[63:32];
    w_regs[4] = {16'h0, r_prescale};
    w_regs[5] = {31'h0, r_en};
    w_regs[6] = r_ackcnt;
    w_regs[7] = {31'h0, w_msip};
  end

  assign w_wsel = r_waddr[4:2];
  assign w_rsel = r_raddr[4:2];
  assign w_wval = merge(w_regs[w_wsel],
                        AXI_Slave.w_data,
                        AXI_Slave.w_strb);

  // ACKCNT is read-only; 0x1C only exists with the SWI build
  assign w_wbad = (w_wsel == A_ACK) ||
                  ((w_wsel == A_SWI) && !SWI);
  assign w_rbad = (w_rsel == A_SWI) && !SWI;

  assign w_we_mtl = w_w_hs && (w_wsel == A_MTL);
  assign w_we_mth = w_w_hs && (w_wsel == A_MTH);
  assign w_we_cml = w_w_hs && (w_wsel == A_CML);
  assign w_we_cmh = w_w_hs && (w_wsel == A_CMH);
  assign w_we_pre = w_w_hs && (w_wsel == A_PRE);
  assign w_we_ctl = w_w_hs && (w_wsel == A_CTL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_live  <= 1'b0;
      r_awid  <= '0;
      r_waddr <= '0;
      r_awlen <= '0;
      r_werr  <= 1'b0;
      r_arid  <= '0;
      r_raddr <= '0;
      r_arlen <= '0;
      r_rcnt  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_aw_hs) begin
        r_awid  <= AXI_Slave.aw_id;
        r_waddr <= AXI_Slave.aw_addr;
        r_awlen <= AXI_Slave.aw_len;
        r_werr  <= 1'b0;
      end else if (w_w_hs) begin
        r_waddr <= r_waddr + AXI_ADDR_WIDTH'(4);
        if (w_wbad) r_werr <= 1'b1;
      end
      if (w_ar_hs) begin
        r_arid  <= AXI_Slave.ar_id;
        r_raddr <= AXI_Slave.ar_addr;
        r_arlen <= AXI_Slave.ar_len;
        r_rcnt  <= '0;
      end else if (w_r_hs) begin
        r_raddr <= r_raddr + AXI_ADDR_WIDTH'(4);
        r_rcnt  <= r_rcnt + 8'd1;
      end
    end
  end

  assign w_tick  = r_en && (r_pcnt == r_prescale);
  assign w_ack_t = irq_ack_i &&
                   (irq_id_i == 5'(TIMER_IRQ_ID));

  // An mtime write drops a coincident tick in both halves
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_prescale <= 16'(PRESCALE_RESET);
      r_pcnt     <= '0;
      r_en       <= 1'b0;
      r_ackcnt   <= '0;
      r_tirq     <= 1'b0;
    end else begin
      if (w_we_pre || w_tick) r_pcnt <= '0;
      else if (r_en) r_pcnt <= r_pcnt + 16'd1;
      if (w_we_mtl) r_mtime[31:0] <= w_wval;
      else if (w_we_mth) r_mtime[63:32] <= w_wval;
      else if (w_tick) r_mtime <= r_mtime + 64'd1;
      if (w_we_cml) r_mtimecmp[31:0] <= w_wval;
      if (w_we_cmh) r_mtimecmp[63:32] <= w_wval;
      if (w_we_pre) r_prescale <= w_wval[15:0];
      if (w_we_ctl) r_en <= w_wval[0];
      if (w_ack_t) r_ackcnt <= r_ackcnt + 32'd1;
      r_tirq <= r_en && (r_mtime >= r_mtimecmp);
    end
  end

`ifdef AXI_TIMER_SWI_EN
  logic r_msip;
  logic w_we_swi;
  assign w_we_swi = w_w_hs && (w_wsel == A_SWI);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_msip <= 1'b0;
    end else if (w_we_swi) begin
      r_msip <= w_wval[0];
    end else if (irq_ack_i && (irq_id_i == 5'd3)) begin
      r_msip <= 1'b0;
    end
  end

  assign w_msip = r_msip;
`else
  assign w_msip = 1'b0;
`endif

  always_comb begin
    irq_o               = '0;
    irq_o[3]            = w_msip;
    irq_o[TIMER_IRQ_ID] = r_tirq;
  end

  assign AXI_Slave.aw_ready = w_awready;
  assign AXI_Slave.w_ready  = w_wready;
  assign AXI_Slave.b_valid  = w_bvalid;
  assign AXI_Slave.b_id     = r_awid;
  assign AXI_Slave.b_resp   = r_werr ? 2'b10 : 2'b00;
  assign AXI_Slave.b_user   = '0;
  assign AXI_Slave.ar_ready = w_arready;
  assign AXI_Slave.r_valid  = w_rvalid;
  assign AXI_Slave.r_id     = r_arid;
  assign AXI_Slave.r_last   = w_rlast;
  assign AXI_Slave.r_data   = w_rbad ? 32'h0 : w_regs[w_rsel];
  assign AXI_Slave.r_resp   = w_rbad ? 2'b10 : 2'b00;
  assign AXI_Slave.r_user   = '0;

  logic w_unused;
  assign w_unused = ^{AXI_Slave.aw_size, AXI_Slave.aw_burst,
                      AXI_Slave.aw_lock, AXI_Slave.aw_cache,
                      AXI_Slave.aw_prot, AXI_Slave.aw_qos,
                      AXI_Slave.aw_region, AXI_Slave.aw_atop,
                      AXI_Slave.aw_user, AXI_Slave.w_user,
                      AXI_Slave.ar_size, AXI_Slave.ar_burst,
                      AXI_Slave.ar_lock, AXI_Slave.ar_cache,
                      AXI_Slave.ar_prot, AXI_Slave.ar_qos,
                      AXI_Slave.ar_region, AXI_Slave.ar_user,
                      r_awlen, r_waddr, r_raddr};

endmodule

// File: tb/tb_axi_timer_irq.sv
// Directed bench for axi_timer_irq: register map, tick/irq
// timing, ack counting, bursts, error responses and reset.
module tb_axi_timer_irq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq;
  logic        ack = 1'b0;
  logic [4:0]  ack_id = 5'd0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_w = 0;
  int t_rise = -1;
  int t_fall = -1;
  logic irq7_q = 1'b0;

  AXI_BUS #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .AXI_ID_WIDTH(16),
    .AXI_USER_WIDTH(10)
  ) axi ();

  axi_timer_irq #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .AXI_ID_WIDTH(16),
    .AXI_USER_WIDTH(10),
    .PRESCALE_RESET(0),
    .TIMER_IRQ_ID(7)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .AXI_Slave(axi),
    .irq_o(irq),
    .irq_ack_i(ack),
    .irq_id_i(ack_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (irq[7] !== irq7_q) begin
      if (irq[7] === 1'b1) t_rise = cyc;
      else t_fall = cyc;
    end
    irq7_q = irq[7];
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  task automatic axi_wr(
    input  logic [31:0] addr,
    input  int          n,
    input  logic [31:0] d [4],
    input  logic [3:0]  strb,
    input  logic [15:0] id,
    output logic [1:0]  resp,
    output logic [15:0] bid
  );
    int k;
    @(posedge clk); #1;
    axi.aw_valid = 1'b1;
    axi.aw_addr  = addr;
    axi.aw_len   = 8'(n - 1);
    axi.aw_id    = id;
    k = 0;
    @(negedge clk);
    while (!axi.aw_ready && k < 100) begin
      @(negedge clk); k++;
    end
    if (!axi.aw_ready) begin
      n_cmp++; n_err++;
      $display("FAIL aw_timeout: got no aw_ready, required 1");
    end
    @(posedge clk); #1;
    axi.aw_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      axi.w_valid = 1'b1;
      axi.w_data  = d[i];
      axi.w_strb  = strb;
      axi.w_last  = (i == n - 1);
      k = 0;
      @(negedge clk);
      while (!axi.w_ready && k < 100) begin
        @(negedge clk); k++;
      end
      if (!axi.w_ready) begin
        n_cmp++; n_err++;
        $display("FAIL w_timeout: got no w_ready, required 1");
      end
      @(posedge clk); #1;
      t_w = cyc;
    end
    axi.w_valid = 1'b0;
    axi.w_last  = 1'b0;
    axi.b_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!axi.b_valid && k < 100) begin
      @(negedge clk); k++;
    end
    if (!axi.b_valid) begin
      n_cmp++; n_err++;
      $display("FAIL b_timeout: got no b_valid, required 1");
    end
    resp = axi.b_resp;
    bid  = axi.b_id;
    @(posedge clk); #1;
    axi.b_ready = 1'b0;
  endtask

  task automatic axi_rd(
    input  logic [31:0] addr,
    input  int          n,
    input  logic [15:0] id,
    output logic [31:0] d [4],
    output logic [1:0]  resp [4],
    output logic [3:0]  last,
    output logic [15:0] rid
  );
    int k;
    d    = '{default: 32'h0};
    resp = '{default: 2'b11};
    last = 4'h0;
    rid  = 16'h0;
    @(posedge clk); #1;
    axi.ar_valid = 1'b1;
    axi.ar_addr  = addr;
    axi.ar_len   = 8'(n - 1);
    axi.ar_id    = id;
    k = 0;
    @(negedge clk);
    while (!axi.ar_ready && k < 100) begin
      @(negedge clk); k++;
    end
    if (!axi.ar_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout: got no ar_ready, required 1");
    end
    @(posedge clk); #1;
    axi.ar_valid = 1'b0;
    axi.r_ready  = 1'b1;
    for (int i = 0; i < n; i++) begin
      k = 0;
      @(negedge clk);
      while (!axi.r_valid && k < 100) begin
        @(negedge clk); k++;
      end
      if (!axi.r_valid) begin
        n_cmp++; n_err++;
        $display("FAIL r_timeout: got no r_valid, required 1");
      end
      d[i]    = axi.r_data;
      resp[i] = axi.r_resp;
      last[i] = axi.r_last;
      rid     = axi.r_id;
      @(posedge clk); #1;
    end
    axi.r_ready = 1'b0;
  endtask

  task automatic wr1(
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  strb,
    output logic [1:0]  resp
  );
    logic [31:0] d [4];
    logic [15:0] bid;
    d = '{data, 32'h0, 32'h0, 32'h0};
    axi_wr(addr, 1, d, strb, 16'h0001, resp, bid);
  endtask

  task automatic rd1(
    input  logic [31:0] addr,
    output logic [31:0] data,
    output logic [1:0]  resp
  );
    logic [31:0] d [4];
    logic [1:0]  rs [4];
    logic [3:0]  l;
    logic [15:0] rid;
    axi_rd(addr, 1, 16'h0002, d, rs, l, rid);
    data = d[0];
    resp = rs[0];
  endtask

  task automatic pulse_ack(input logic [4:0] id);
    @(posedge clk); #1;
    ack = 1'b1; ack_id = id;
    @(posedge clk); #1;
    ack = 1'b0; ack_id = 5'd0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic [1:0]  r;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({axi.aw_ready, axi.ar_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_ready: got %b, required 00",
               {axi.aw_ready, axi.ar_ready});
    end
    n_cmp++;
    if ({axi.b_valid, axi.r_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_valid: got %b, required 00",
               {axi.b_valid, axi.r_valid});
    end
    n_cmp++;
    if (irq !== 32'h0) begin
      n_err++;
      $display("FAIL rst_irq: got %h, required 0", irq);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd1(32'h3000_0008, v, r);
    n_cmp++;
    if ({r, v} !== {2'b00, 32'hFFFF_FFFF}) begin
      n_err++;
      $display("FAIL rst_cmplo: got %h/%b, required ffffffff/00",
               v, r);
    end
    rd1(32'h3000_000C, v, r);
    n_cmp++;
    if ({r, v} !== {2'b00, 32'hFFFF_FFFF}) begin
      n_err++;
      $display("FAIL rst_cmphi: got %h/%b, required ffffffff/00",
               v, r);
    end
    rd1(32'h3000_0014, v, r);
    n_cmp++;
    if ({r, v} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL rst_ctrl: got %h/%b, required 0/00", v, r);
    end
  endtask

  task automatic test_timer;
    logic [31:0] v;
    logic [1:0]  r;
    int t_en;
    int k;
    wr1(32'h3000_0010, 32'd3, 4'hF, r);
    wr1(32'h3000_000C, 32'd0, 4'hF, r);
    wr1(32'h3000_0008, 32'd10, 4'hF, r);
    wr1(32'h3000_0014, 32'd1, 4'hF, r);
    t_en = t_w;
    k = 0;
    while (irq[7] !== 1'b1 && k < 200) begin
      @(negedge clk); k++;
    end
    #1;
    n_cmp++;
    if (t_rise - t_en != 41) begin
      n_err++;
      $display("FAIL irq_rise: got %0d cycles, required 41",
               t_rise - t_en);
    end
    rd1(32'h3000_0000, v, r);
    n_cmp++;
    if (v < 32'd10 || r !== 2'b00) begin
      n_err++;
      $display("FAIL mtime_lo: got %0d/%b, required >=10/00",
               v, r);
    end
  endtask

  task automatic test_clear;
    logic [1:0] r;
    int t_c;
    wr1(32'h3000_0008, 32'hFFFF_FFFF, 4'hF, r);
    t_c = t_w;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (t_fall - t_c != 1 || irq[7] !== 1'b0) begin
      n_err++;
      $display("FAIL irq_fall: got %0d cycles irq7=%b, required 1/0",
               t_fall - t_c, irq[7]);
    end
  endtask

  task automatic test_ack;
    logic [31:0] v;
    logic [1:0]  r;
    pulse_ack(5'd7);
    pulse_ack(5'd11);
    pulse_ack(5'd7);
    pulse_ack(5'd7);
    rd1(32'h3000_0018, v, r);
    n_cmp++;
    if ({r, v} !== {2'b00, 32'd3}) begin
      n_err++;
      $display("FAIL ackcnt: got %0d/%b, required 3/00", v, r);
    end
  endtask

  task automatic test_burst;
    logic [31:0] d [4];
    logic [1:0]  rs [4];
    logic [3:0]  l;
    logic [15:0] id;
    logic [1:0]  r;
    d = '{32'd5, 32'd0, 32'd100, 32'd0};
    axi_wr(32'h3000_0000, 4, d, 4'hF, 16'h1234, r, id);
    n_cmp++;
    if (r !== 2'b00) begin
      n_err++;
      $display("FAIL burst_bresp: got %b, required 00", r);
    end
    n_cmp++;
    if (id !== 16'h1234) begin
      n_err++;
      $display("FAIL burst_bid: got %h, required 1234", id);
    end
    axi_rd(32'h3000_0000, 4, 16'h0ABC, d, rs, l, id);
    n_cmp++;
    if (l !== 4'b1000) begin
      n_err++;
      $display("FAIL burst_rlast: got %b, required 1000", l);
    end
    n_cmp++;
    if (d[2] !== 32'd100 || d[1] !== 32'd0) begin
      n_err++;
      $display("FAIL burst_data: got %0d,%0d, required 0,100",
               d[1], d[2]);
    end
    n_cmp++;
    if (id !== 16'h0ABC) begin
      n_err++;
      $display("FAIL burst_rid: got %h, required 0abc", id);
    end
    n_cmp++;
    if ({rs[0], rs[1], rs[2], rs[3]} !== 8'h00) begin
      n_err++;
      $display("FAIL burst_rresp: got %b%b%b%b, required 0",
               rs[0], rs[1], rs[2], rs[3]);
    end
  endtask

  task automatic test_strobe;
    logic [31:0] v;
    logic [1:0]  r;
    wr1(32'h3000_000C, 32'hAABB_CCDD, 4'b0010, r);
    rd1(32'h3000_000C, v, r);
    n_cmp++;
    if (v !== 32'h0000_CC00) begin
      n_err++;
      $display("FAIL strobe: got %h, required 0000cc00", v);
    end
    wr1(32'h3000_0010, 32'h1234_0003, 4'hF, r);
    rd1(32'h3000_0010, v, r);
    n_cmp++;
    if (v !== 32'h0000_0003) begin
      n_err++;
      $display("FAIL prescale_hi: got %h, required 00000003", v);
    end
  endtask

  task automatic test_errors;
    logic [31:0] v;
    logic [1:0]  r;
    rd1(32'h3000_001C, v, r);
`ifdef AXI_TIMER_SWI_EN
    n_cmp++;
    if ({r, v} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL msip_rd: got %h/%b, required 0/00", v, r);
    end
`else
    n_cmp++;
    if ({r, v} !== {2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL unmapped_rd: got %h/%b, required 0/10", v, r);
    end
`endif
    wr1(32'h3000_0018, 32'h55, 4'hF, r);
    n_cmp++;
    if (r !== 2'b10) begin
      n_err++;
      $display("FAIL ro_wr: got %b, required 10", r);
    end
    rd1(32'h3000_0018, v, r);
    n_cmp++;
    if (v !== 32'd3) begin
      n_err++;
      $display("FAIL ro_keep: got %0d, required 3", v);
    end
`ifdef AXI_TIMER_SWI_EN
    wr1(32'h3000_001C, 32'h1, 4'hF, r);
    @(negedge clk);
    n_cmp++;
    if ({r, irq[3]} !== 3'b001) begin
      n_err++;
      $display("FAIL msip_set: got %b/%b, required 00/1", r, irq[3]);
    end
    pulse_ack(5'd3);
    @(negedge clk);
    n_cmp++;
    if (irq[3] !== 1'b0) begin
      n_err++;
      $display("FAIL msip_clr: got %b, required 0", irq[3]);
    end
`else
    n_cmp++;
    if (irq[3] !== 1'b0) begin
      n_err++;
      $display("FAIL irq3: got %b, required 0", irq[3]);
    end
`endif
  endtask

  task automatic test_wrap;
    logic [31:0] v;
    logic [1:0]  r;
    wr1(32'h3000_0014, 32'h0, 4'hF, r);
    wr1(32'h3000_0010, 32'h0, 4'hF, r);
    wr1(32'h3000_0000, 32'hFFFF_FFFF, 4'hF, r);
    wr1(32'h3000_0004, 32'hFFFF_FFFF, 4'hF, r);
    rd1(32'h3000_0004, v, r);
    n_cmp++;
    if (v !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL hold_hi: got %h, required ffffffff", v);
    end
    wr1(32'h3000_0014, 32'h1, 4'hF, r);
    rd1(32'h3000_0004, v, r);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_hi: got %h, required 0", v);
    end
    rd1(32'h3000_0000, v, r);
    n_cmp++;
    if (v == 32'h0 || v > 32'd64) begin
      n_err++;
      $display("FAIL wrap_lo: got %0d, required 1..64", v);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    logic [1:0]  r;
    int k;
    int seen;
    @(posedge clk); #1;
    axi.aw_valid = 1'b1;
    axi.aw_addr  = 32'h3000_0008;
    axi.aw_len   = 8'd0;
    axi.aw_id    = 16'h0077;
    k = 0;
    @(negedge clk);
    while (!axi.aw_ready && k < 100) begin
      @(negedge clk); k++;
    end
    @(posedge clk); #1;
    axi.aw_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    axi.b_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axi.b_valid === 1'b1) seen++;
    end
    axi.b_ready = 1'b0;
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL mid_bvalid: got %0d beats, required 0", seen);
    end
    rd1(32'h3000_0008, v, r);
    n_cmp++;
    if (v !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL mid_cmplo: got %h, required ffffffff", v);
    end
    rd1(32'h3000_0000, v, r);
    n_cmp++;
    if (v !== 32'h0 || irq !== 32'h0) begin
      n_err++;
      $display("FAIL mid_state: got mtime %h irq %h, required 0/0",
               v, irq);
    end
  endtask

  initial begin
    axi.aw_id = '0;     axi.aw_addr = '0;  axi.aw_len = '0;
    axi.aw_size = 3'd2; axi.aw_burst = 2'b01;
    axi.aw_lock = 1'b0; axi.aw_cache = '0; axi.aw_prot = '0;
    axi.aw_qos = '0;    axi.aw_region = '0; axi.aw_atop = '0;
    axi.aw_user = '0;   axi.aw_valid = 1'b0;
    axi.w_data = '0;    axi.w_strb = '0;   axi.w_last = 1'b0;
    axi.w_user = '0;    axi.w_valid = 1'b0;
    axi.b_ready = 1'b0;
    axi.ar_id = '0;     axi.ar_addr = '0;  axi.ar_len = '0;
    axi.ar_size = 3'd2; axi.ar_burst = 2'b01;
    axi.ar_lock = 1'b0; axi.ar_cache = '0; axi.ar_prot = '0;
    axi.ar_qos = '0;    axi.ar_region = '0;
    axi.ar_user = '0;   axi.ar_valid = 1'b0;
    axi.r_ready = 1'b0;

    test_reset();
    test_timer();
    test_clear();
    test_ack();
    test_burst();
    test_strobe();
    test_errors();
    test_wrap();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
